// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4 memory responder: one read and one write burst in flight,
// byte strobes, SLVERR on bad beats, LFSR-driven handshake delays.
module ysyx_25040111_axi_mem_slave #(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          DEPTH    = 4096,
  parameter bit          DELAY_EN = 1'b1,
  parameter int          DELAY_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [3:0]  rid,
  output logic        rlast
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rst_t;

  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[AW+1:2];
  endfunction

  // WRAP (2'b10) and reserved (2'b11) both have bit 1 set
  function automatic logic bad_cfg(input logic [2:0] s, input logic [1:0] b);
    return (s > 3'd2) || b[1];
  endfunction

  logic [7:0]         lfsr;
  logic [DELAY_W-1:0] dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign dly = DELAY_EN ? lfsr[DELAY_W-1:0] : '0;

  wst_t               wstate;
  logic [31:0]        waddr;
  logic [3:0]         wid;
  logic [7:0]         wlen, wbeat;
  logic [2:0]         wsize;
  logic [1:0]         wburst;
  logic [DELAY_W-1:0] wcnt;
  logic               wcfg, werr;
  logic               w_fire, w_end, w_ok, w_bad;
  logic [31:0]        wnext;

  assign w_fire = wvalid & wready;
  assign w_end  = wbeat == wlen;
  assign w_ok   = ~wcfg & in_range(waddr);
  assign w_bad  = ~w_ok | (wlast != w_end);
  assign wnext  = (wburst == 2'b01) ? waddr + (32'd1 << wsize) : waddr;

  always_ff @(posedge clk) begin
    if (w_fire && w_ok)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[widx(waddr)][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      bid     <= 4'd0;
      waddr   <= 32'd0;
      wid     <= 4'd0;
      wlen    <= 8'd0;
      wbeat   <= 8'd0;
      wsize   <= 3'd0;
      wburst  <= 2'd0;
      wcnt    <= '0;
      wcfg    <= 1'b0;
      werr    <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            waddr   <= awaddr;
            wid     <= awid;
            wlen    <= awlen;
            wsize   <= awsize;
            wburst  <= awburst;
            wbeat   <= 8'd0;
            wcnt    <= dly;
            wready  <= (dly == '0);
            wcfg    <= bad_cfg(awsize, awburst);
            werr    <= bad_cfg(awsize, awburst);
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wcnt != '0) begin
            wcnt   <= wcnt - 1'b1;
            wready <= (wcnt == DELAY_W'(1));
          end
          if (w_fire) begin
            waddr <= wnext;
            wbeat <= wbeat + 8'd1;
            if (w_bad) werr <= 1'b1;
            if (w_end) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= wid;
              bresp  <= (werr | w_bad) ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  rst_t               rstate;
  logic [31:0]        raddr, rnext, paddr, pdata;
  logic [7:0]         rlen, rbeat;
  logic [2:0]         rsize;
  logic [1:0]         rburst;
  logic [DELAY_W-1:0] rcnt;
  logic               rcfg, pcfg, pok;

  assign rnext = (rburst == 2'b01) ? raddr + (32'd1 << rsize) : raddr;

  // Address of the beat that would be presented at the next edge
  always_comb begin
    paddr = raddr;
    pcfg  = rcfg;
    unique case (rstate)
      R_IDLE: begin
        paddr = araddr;
        pcfg  = bad_cfg(arsize, arburst);
      end
      R_DATA:  paddr = rnext;
      default: ;
    endcase
  end

  assign pok   = ~pcfg & in_range(paddr);
  assign pdata = mem[widx(paddr)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
      rid     <= 4'd0;
      raddr   <= 32'd0;
      rlen    <= 8'd0;
      rbeat   <= 8'd0;
      rsize   <= 3'd0;
      rburst  <= 2'd0;
      rcnt    <= '0;
      rcfg    <= 1'b0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            raddr   <= araddr;
            rid     <= arid;
            rlen    <= arlen;
            rsize   <= arsize;
            rburst  <= arburst;
            rbeat   <= 8'd0;
            rcfg    <= pcfg;
            rcnt    <= dly;
            if (dly == '0) begin
              rvalid <= 1'b1;
              rdata  <= pok ? pdata : 32'd0;
              rresp  <= pok ? 2'b00 : 2'b10;
              rlast  <= (arlen == 8'd0);
              rstate <= R_DATA;
            end else begin
              rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          rcnt <= rcnt - 1'b1;
          if (rcnt <= DELAY_W'(1)) begin
            rvalid <= 1'b1;
            rdata  <= pok ? pdata : 32'd0;
            rresp  <= pok ? 2'b00 : 2'b10;
            rlast  <= (rbeat == rlen);
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rbeat == rlen) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              raddr <= rnext;
              rbeat <= rbeat + 8'd1;
              rcnt  <= dly;
              if (dly == '0) begin
                rdata <= pok ? pdata : 32'd0;
                rresp <= pok ? 2'b00 : 2'b10;
                rlast <= ((rbeat + 8'd1) == rlen);
              end else begin
                rvalid <= 1'b0;
                rstate <= R_WAIT;
              end
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
